// File: rtl/dp_stage.sv
// dp_stage: 2-wide in-order dispatch stage between rename and ROB/RS/LSQ.
// Define DP_STAT_EN to build the dispatched/stall-cycle statistics counters.
typedef struct packed {
    logic        valid;
    logic        halt;
    logic        illegal;
    logic        rd_mem;
    logic        wr_mem;
    logic [6:0]  dest_prn;
    logic [31:0] pc;
} RN_DP_PACKET;

module dp_stage #(
    parameter int CNT_WIDTH = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  rollback_en,
    input  RN_DP_PACKET [1:0]     rn_packet_in,
    input  logic [CNT_WIDTH-1:0]  rob_free,
    input  logic [CNT_WIDTH-1:0]  rs_free,
    input  logic [CNT_WIDTH-1:0]  lsq_free,
    output RN_DP_PACKET [1:0]     dp_packet_out,
    output logic [1:0]            dp_en,
    output logic [1:0]            dp_mem_en,
    output logic                  rn_stall,
    output logic [31:0]           stat_dispatched,
    output logic [31:0]           stat_stall_cycles
);
    RN_DP_PACKET [1:0] slot;
    RN_DP_PACKET [1:0] fill;
    RN_DP_PACKET       in0;
    RN_DP_PACKET       in1;
    logic [1:0]        rs_need;
    logic [1:0]        lsq_need;
    logic              d0;
    logic              d1;
    logic              drop;
    logic              all_done;

    for (genvar i = 0; i < 2; i++) begin : g_need
        assign rs_need[i]  = slot[i].valid && !slot[i].halt && !slot[i].illegal;
        assign lsq_need[i] = slot[i].valid && (slot[i].rd_mem || slot[i].wr_mem);
    end

    // slot1 is checked against the combined demand of both slots
    assign d0 = slot[0].valid && rob_free != '0
             && rs_free  >= CNT_WIDTH'(rs_need[0])
             && lsq_free >= CNT_WIDTH'(lsq_need[0]);
    assign d1 = d0 && !slot[0].halt && slot[1].valid
             && rob_free >= CNT_WIDTH'(2)
             && rs_free  >= CNT_WIDTH'({1'b0, rs_need[0]} + {1'b0, rs_need[1]})
             && lsq_free >= CNT_WIDTH'({1'b0, lsq_need[0]} + {1'b0, lsq_need[1]});

    assign dp_en         = {d1, d0};
    assign dp_mem_en     = dp_en & lsq_need;
    assign dp_packet_out = slot;
    assign rn_stall      = !rollback_en && ((slot[0].valid && !d0) || (slot[1].valid && !d1));
    assign drop          = d0 && slot[0].halt && slot[1].valid;
    assign all_done      = (!slot[0].valid || d0) && (!slot[1].valid || d1);

    // invalid packets are stored as zero; a lone younger packet is compacted into slot0
    assign in0  = rn_packet_in[0].valid ? rn_packet_in[0] : '0;
    assign in1  = rn_packet_in[1].valid ? rn_packet_in[1] : '0;
    assign fill = in0.valid ? {in1, in0} : {RN_DP_PACKET'('0), in1};

    always_ff @(posedge clock) begin
        if (reset || rollback_en || drop)
            slot <= '0;
        else if (all_done)
            slot <= fill;
        else if (d0)
            slot <= {RN_DP_PACKET'('0), slot[1]};
    end

`ifdef DP_STAT_EN
    logic [31:0] disp_cnt;
    logic [31:0] stall_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            disp_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            disp_cnt  <= disp_cnt + 32'(d0) + 32'(d1);
            stall_cnt <= stall_cnt + 32'(rn_stall);
        end
    end

    assign stat_dispatched   = disp_cnt;
    assign stat_stall_cycles = stall_cnt;
`else
    assign stat_dispatched   = '0;
    assign stat_stall_cycles = '0;
`endif
endmodule

// File: tb/tb_dp_stage.sv
// tb_dp_stage: directed self-checking bench for dp_stage.
module tb_dp_stage;
    logic              clock;
    logic              reset;
    logic              rollback_en;
    RN_DP_PACKET [1:0] rn_packet_in;
    logic [4:0]        rob_free;
    logic [4:0]        rs_free;
    logic [4:0]        lsq_free;
    RN_DP_PACKET [1:0] dp_packet_out;
    logic [1:0]        dp_en;
    logic [1:0]        dp_mem_en;
    logic              rn_stall;
    logic [31:0]       stat_dispatched;
    logic [31:0]       stat_stall_cycles;
    int                checks = 0;
    int                errors = 0;

    dp_stage #(.CNT_WIDTH(5)) dut (
        .clock(clock), .reset(reset), .rollback_en(rollback_en),
        .rn_packet_in(rn_packet_in), .rob_free(rob_free), .rs_free(rs_free),
        .lsq_free(lsq_free), .dp_packet_out(dp_packet_out), .dp_en(dp_en),
        .dp_mem_en(dp_mem_en), .rn_stall(rn_stall),
        .stat_dispatched(stat_dispatched), .stat_stall_cycles(stat_stall_cycles)
    );

    initial clock = 0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic RN_DP_PACKET mk(input logic h, input logic il, input logic rd,
                                       input logic wr, input logic [31:0] pc);
        mk = '0;
        mk.valid = 1'b1;
        mk.halt = h;
        mk.illegal = il;
        mk.rd_mem = rd;
        mk.wr_mem = wr;
        mk.dest_prn = pc[8:2];
        mk.pc = pc;
    endfunction

    initial begin
        int n;
        reset = 1; rollback_en = 0; rn_packet_in = '0;
        rob_free = 4; rs_free = 4; lsq_free = 4;
        tick(); tick();
        chk("rst_dp_en", 64'(dp_en), 0);
        chk("rst_stall", 64'(rn_stall), 0);
        chk("rst_slot0_valid", 64'(dp_packet_out[0].valid), 0);
        chk("rst_stat_disp", 64'(stat_dispatched), 0);
        chk("rst_stat_stall", 64'(stat_stall_cycles), 0);

        reset = 0;
        rn_packet_in = {mk(0,0,0,0,32'h104), mk(0,0,0,0,32'h100)};
        #1 chk("empty_dp_en", 64'(dp_en), 0);
        tick();
        rn_packet_in = {mk(0,0,1,0,32'h204), mk(0,0,1,0,32'h200)};
        #1;
        chk("alu_pair_dp_en", 64'(dp_en), 2'b11);
        chk("alu_pair_stall", 64'(rn_stall), 0);
        chk("alu_pair_pc0", 64'(dp_packet_out[0].pc), 32'h100);
        chk("alu_pair_pc1", 64'(dp_packet_out[1].pc), 32'h104);
        tick();

        lsq_free = 1;
        rn_packet_in = {mk(0,0,0,0,32'h304), mk(0,0,0,0,32'h300)};
        #1;
        chk("ld_part_dp_en", 64'(dp_en), 2'b01);
        chk("ld_part_mem", 64'(dp_mem_en), 2'b01);
        chk("ld_part_stall", 64'(rn_stall), 1);
        chk("ld_part_pc0", 64'(dp_packet_out[0].pc), 32'h200);
        tick();
        chk("ld_shift_dp_en", 64'(dp_en), 2'b01);
        chk("ld_shift_mem", 64'(dp_mem_en), 2'b01);
        chk("ld_shift_stall", 64'(rn_stall), 0);
        chk("ld_shift_pc0", 64'(dp_packet_out[0].pc), 32'h204);
        chk("ld_shift_slot1_valid", 64'(dp_packet_out[1].valid), 0);
        tick();

        rob_free = 0; lsq_free = 4;
        rn_packet_in = {mk(0,0,0,1,32'h404), mk(0,0,0,0,32'h400)};
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("rob0_dp_en", 64'(dp_en), 0);
            chk("rob0_stall", 64'(rn_stall), 1);
            chk("rob0_pc0", 64'(dp_packet_out[0].pc), 32'h300);
            chk("rob0_pc1", 64'(dp_packet_out[1].pc), 32'h304);
            tick();
        end
        rob_free = 2;
        #1;
        chk("rob2_dp_en", 64'(dp_en), 2'b11);
        chk("rob2_stall", 64'(rn_stall), 0);
        tick();

        rob_free = 4; lsq_free = 0;
        #1;
        chk("st_block_dp_en", 64'(dp_en), 2'b01);
        chk("st_block_mem", 64'(dp_mem_en), 2'b00);
        chk("st_block_stall", 64'(rn_stall), 1);
        rollback_en = 1;
        rn_packet_in = {mk(0,0,0,0,32'h904), mk(0,0,0,0,32'h900)};
        #1 chk("rollback_stall", 64'(rn_stall), 0);
        tick();
        rollback_en = 0; lsq_free = 4;
        rn_packet_in = {mk(0,0,0,0,32'h504), mk(1,0,0,0,32'h500)};
        #1;
        chk("post_rb_dp_en", 64'(dp_en), 0);
        chk("post_rb_slot0_valid", 64'(dp_packet_out[0].valid), 0);
        chk("post_rb_slot1_valid", 64'(dp_packet_out[1].valid), 0);
        chk("post_rb_stall", 64'(rn_stall), 0);
        tick();

        rs_free = 0;
        rn_packet_in = {mk(0,0,0,0,32'h604), mk(0,0,0,0,32'h600)};
        #1;
        chk("halt_dp_en", 64'(dp_en), 2'b01);
        chk("halt_stall", 64'(rn_stall), 1);
        chk("halt_pc0", 64'(dp_packet_out[0].pc), 32'h500);
        tick();
        chk("halt_drop_slot0", 64'(dp_packet_out[0].valid), 0);
        chk("halt_drop_slot1", 64'(dp_packet_out[1].valid), 0);
        chk("halt_drop_dp_en", 64'(dp_en), 0);
        rs_free = 4;
        tick();
        rn_packet_in = {mk(0,0,0,0,32'h704), RN_DP_PACKET'('0)};
        #1;
        chk("refill_dp_en", 64'(dp_en), 2'b11);
        chk("refill_pc0", 64'(dp_packet_out[0].pc), 32'h600);
        tick();
        rn_packet_in = '0;
        chk("compact_pc0", 64'(dp_packet_out[0].pc), 32'h704);
        chk("compact_slot1_valid", 64'(dp_packet_out[1].valid), 0);
        chk("compact_dp_en", 64'(dp_en), 2'b01);
        tick();

        rn_packet_in = {mk(0,0,0,0,32'h804), mk(0,1,0,0,32'h800)};
        tick();
        rn_packet_in = '0; rs_free = 1;
        #1 chk("illegal_rs1_dp_en", 64'(dp_en), 2'b11);
        tick();
        rs_free = 4;

        reset = 1;
        tick();
        reset = 0;
        #1;
        chk("stat_rst_disp", 64'(stat_dispatched), 0);
        chk("stat_rst_stall", 64'(stat_stall_cycles), 0);
        n = 1;
        rn_packet_in = {mk(0,0,0,0,32'h1004), mk(0,0,0,0,32'h1000)};
        tick();
        for (int k = 0; k < 12; k++) begin
            rob_free = (k == 3 || k == 4) ? 5'd0 : 5'd4;
            #1;
            if (k == 3 || k == 4) begin
                chk("stat_run_stall_dp_en", 64'(dp_en), 0);
                chk("stat_run_stall", 64'(rn_stall), 1);
            end else begin
                chk("stat_run_dp_en", 64'(dp_en), 2'b11);
                chk("stat_run_pc0", 64'(dp_packet_out[0].pc), 64'(32'h1000 + 32'(n - 1) * 8));
                n++;
                rn_packet_in = (n <= 10) ? {mk(0,0,0,0,32'h1004 + 32'(n - 1) * 8),
                                            mk(0,0,0,0,32'h1000 + 32'(n - 1) * 8)} : '0;
            end
            tick();
        end
        chk("stat_run_empty", 64'(dp_packet_out[0].valid), 0);
`ifdef DP_STAT_EN
        chk("stat_dispatched", 64'(stat_dispatched), 20);
        chk("stat_stall_cycles", 64'(stat_stall_cycles), 2);
`else
        chk("stat_dispatched_off", 64'(stat_dispatched), 0);
        chk("stat_stall_cycles_off", 64'(stat_stall_cycles), 0);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
